// File: rtl/mem_wb_stage_pkg.sv
// Encodings shared by the decoder, hazard unit and the MEM/WB stage:
// load modes and the register-file write-source select.
package mem_wb_stage_pkg;

  localparam int DATA_W_SUPPORTED = 32;

  localparam logic [2:0] LOAD_LW  = 3'b000;
  localparam logic [2:0] LOAD_LBU = 3'b001;
  localparam logic [2:0] LOAD_LB  = 3'b010;
  localparam logic [2:0] LOAD_LHU = 3'b011;
  localparam logic [2:0] LOAD_LH  = 3'b100;
  localparam logic [2:0] LOAD_LWL = 3'b101;
  localparam logic [2:0] LOAD_LWR = 3'b110;

  localparam logic [1:0] MEMTOREG_ALU  = 2'b00;
  localparam logic [1:0] MEMTOREG_LOAD = 2'b01;
  localparam logic [1:0] MEMTOREG_PC8  = 2'b10;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Combinational load alignment: picks byte/half lanes, extends them, and merges
// LWL/LWR with the old rt value. Lane mapping mirrors the memory's SWL/SWR.
module load_align
  import mem_wb_stage_pkg::*;
(
  input  logic [31:0] m,
  input  logic [31:0] r,
  input  logic [1:0]  a,
  input  logic [2:0]  mode,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] lwl_val;
  logic [31:0] lwr_val;

  always_comb begin
    byte_sel = m[7:0];
    lwl_val  = m;
    lwr_val  = m;
    case (a)
      2'd0: begin
        byte_sel = m[7:0];
        lwl_val  = {m[7:0], r[23:0]};
        lwr_val  = m;
      end
      2'd1: begin
        byte_sel = m[15:8];
        lwl_val  = {m[15:0], r[15:0]};
        lwr_val  = {r[31:24], m[31:8]};
      end
      2'd2: begin
        byte_sel = m[23:16];
        lwl_val  = {m[23:0], r[7:0]};
        lwr_val  = {r[31:16], m[31:16]};
      end
      default: begin
        byte_sel = m[31:24];
        lwl_val  = m;
        lwr_val  = {r[31:8], m[31:24]};
      end
    endcase
  end

  // Halfword accesses ignore a[0]; misalignment is trapped upstream.
  assign half_sel = a[1] ? m[31:16] : m[15:0];

  always_comb begin
    result = m;
    case (mode)
      LOAD_LBU: result = {24'h0, byte_sel};
      LOAD_LB:  result = {{24{byte_sel[7]}}, byte_sel};
      LOAD_LHU: result = {16'h0, half_sel};
      LOAD_LH:  result = {{16{half_sel[15]}}, half_sel};
      LOAD_LWL: result = lwl_val;
      LOAD_LWR: result = lwr_val;
      default:  result = m;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with write-back result selection. Reset and flush
// clear every W register; stall holds them all.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [DATA_W-1:0]     ReadDataM,
  input  logic [1:0]            AddrLow2M,
  input  logic [2:0]            LoadModeM,
  input  logic [DATA_W-1:0]     RtDataM,
  input  logic [DATA_W-1:0]     ALUOutM,
  input  logic [DATA_W-1:0]     PC8M,
  input  logic [1:0]            MemtoRegM,
  input  logic                  RegWriteM,
  input  logic [REG_ADDR_W-1:0] WriteRegM,
  output logic                  RegWriteW,
  output logic [REG_ADDR_W-1:0] WriteRegW,
  output logic [DATA_W-1:0]     ResultW,
  output logic [DATA_W-1:0]     PC8W
);

  logic [DATA_W-1:0]     read_data_q;
  logic [1:0]            addr_low_q;
  logic [2:0]            load_mode_q;
  logic [DATA_W-1:0]     rt_data_q;
  logic [DATA_W-1:0]     alu_out_q;
  logic [DATA_W-1:0]     pc8_q;
  logic [1:0]            memtoreg_q;
  logic                  regwrite_q;
  logic [REG_ADDR_W-1:0] writereg_q;
  logic [DATA_W-1:0]     load_result;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      read_data_q <= '0;
      addr_low_q  <= '0;
      load_mode_q <= '0;
      rt_data_q   <= '0;
      alu_out_q   <= '0;
      pc8_q       <= '0;
      memtoreg_q  <= '0;
      regwrite_q  <= 1'b0;
      writereg_q  <= '0;
    end else if (!stall) begin
      read_data_q <= ReadDataM;
      addr_low_q  <= AddrLow2M;
      load_mode_q <= LoadModeM;
      rt_data_q   <= RtDataM;
      alu_out_q   <= ALUOutM;
      pc8_q       <= PC8M;
      memtoreg_q  <= MemtoRegM;
      regwrite_q  <= RegWriteM;
      writereg_q  <= WriteRegM;
    end
  end

  load_align u_load_align (
    .m      (read_data_q),
    .r      (rt_data_q),
    .a      (addr_low_q),
    .mode   (load_mode_q),
    .result (load_result)
  );

  always_comb begin
    ResultW = alu_out_q;
    case (memtoreg_q)
      MEMTOREG_LOAD: ResultW = load_result;
      MEMTOREG_PC8:  ResultW = pc8_q;
      default:       ResultW = alu_out_q;
    endcase
  end

  // Writes to $0 are suppressed here so the forwarding unit never sees them either.
  assign RegWriteW = regwrite_q & (writereg_q != '0);
  assign WriteRegW = writereg_q;
  assign PC8W      = pc8_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage: reset, load alignment,
// stall/flush behaviour, $0 guard and PC+8 selection.
module tb_mem_wb_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [31:0] ReadDataM;
  logic [1:0]  AddrLow2M;
  logic [2:0]  LoadModeM;
  logic [31:0] RtDataM;
  logic [31:0] ALUOutM;
  logic [31:0] PC8M;
  logic [1:0]  MemtoRegM;
  logic        RegWriteM;
  logic [4:0]  WriteRegM;
  logic        RegWriteW;
  logic [4:0]  WriteRegW;
  logic [31:0] ResultW;
  logic [31:0] PC8W;

  int pass_cnt;
  int total_cnt;

  mem_wb_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .flush     (flush),
    .ReadDataM (ReadDataM),
    .AddrLow2M (AddrLow2M),
    .LoadModeM (LoadModeM),
    .RtDataM   (RtDataM),
    .ALUOutM   (ALUOutM),
    .PC8M      (PC8M),
    .MemtoRegM (MemtoRegM),
    .RegWriteM (RegWriteM),
    .WriteRegM (WriteRegM),
    .RegWriteW (RegWriteW),
    .WriteRegW (WriteRegW),
    .ResultW   (ResultW),
    .PC8W      (PC8W)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; RegWriteM = 1'b1; WriteRegM = 5'd5;
    ALUOutM = 32'hDEADBEEF; PC8M = 32'h00000400; MemtoRegM = 2'b00;
    for (int i = 0; i < 4; i++) begin
      step();
      total_cnt++;
      if (RegWriteW !== 1'b0) $display("FAIL reset_regwrite cyc%0d got %b want 0", i, RegWriteW);
      else pass_cnt++;
      total_cnt++;
      if (ResultW !== 32'h0) $display("FAIL reset_result cyc%0d got %h want 00000000", i, ResultW);
      else pass_cnt++;
      total_cnt++;
      if (WriteRegW !== 5'd0 || PC8W !== 32'h0)
        $display("FAIL reset_wreg_pc8 cyc%0d got %0d/%h want 0/00000000", i, WriteRegW, PC8W);
      else pass_cnt++;
    end
    reset = 1'b0;
  endtask

  task automatic run_load_vectors(input string name, input logic [31:0] m, input logic [31:0] r,
                                  input logic [2:0] modes[], input logic [1:0] addrs[],
                                  input logic [31:0] exps[]);
    ReadDataM = m; RtDataM = r; MemtoRegM = 2'b01; RegWriteM = 1'b1; WriteRegM = 5'd3;
    for (int i = 0; i < modes.size(); i++) begin
      LoadModeM = modes[i]; AddrLow2M = addrs[i];
      step();
      total_cnt++;
      if (ResultW !== exps[i])
        $display("FAIL %s mode=%0d a=%0d got %h want %h", name, modes[i], addrs[i], ResultW, exps[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_byte_loads();
    logic [2:0]  modes[] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b001, 3'b001, 3'b000, 3'b111};
    logic [1:0]  addrs[] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd2, 2'd1};
    logic [31:0] exps[]  = '{32'h00000001, 32'h0000007F, 32'hFFFFFFFF, 32'hFFFFFF80,
                             32'h00000080, 32'h000000FF, 32'h80FF7F01, 32'h80FF7F01};
    run_load_vectors("byte_load", 32'h80FF7F01, 32'h0, modes, addrs, exps);
  endtask

  task automatic test_half_loads();
    logic [2:0]  modes[] = '{3'b100, 3'b100, 3'b011, 3'b011, 3'b100};
    logic [1:0]  addrs[] = '{2'd2, 2'd0, 2'd0, 2'd3, 2'd1};
    logic [31:0] exps[]  = '{32'hFFFF8001, 32'hFFFFFFFE, 32'h0000FFFE, 32'h00008001, 32'hFFFFFFFE};
    run_load_vectors("half_load", 32'h8001FFFE, 32'h0, modes, addrs, exps);
  endtask

  task automatic test_lwl_lwr();
    logic [2:0]  modes[] = '{3'b101, 3'b101, 3'b101, 3'b101, 3'b110, 3'b110, 3'b110, 3'b110};
    logic [1:0]  addrs[] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    logic [31:0] exps[]  = '{32'hDD223344, 32'hCCDD3344, 32'hBBCCDD44, 32'hAABBCCDD,
                             32'hAABBCCDD, 32'h11AABBCC, 32'h1122AABB, 32'h112233AA};
    run_load_vectors("lwl_lwr", 32'hAABBCCDD, 32'h11223344, modes, addrs, exps);
  endtask

  task automatic test_stall_flush();
    ALUOutM = 32'h00001234; MemtoRegM = 2'b00; RegWriteM = 1'b1; WriteRegM = 5'd7;
    PC8M = 32'h00000108;
    step();
    total_cnt++;
    if (ResultW !== 32'h00001234 || WriteRegW !== 5'd7 || RegWriteW !== 1'b1)
      $display("FAIL capture_A got %h/%0d/%b want 00001234/7/1", ResultW, WriteRegW, RegWriteW);
    else pass_cnt++;
    stall = 1'b1;
    ALUOutM = 32'h00005678; WriteRegM = 5'd9; PC8M = 32'h00000208; RegWriteM = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      total_cnt++;
      if (ResultW !== 32'h00001234 || WriteRegW !== 5'd7 || RegWriteW !== 1'b1 || PC8W !== 32'h00000108)
        $display("FAIL stall_hold cyc%0d got %h/%0d/%b/%h want 00001234/7/1/00000108",
                 i, ResultW, WriteRegW, RegWriteW, PC8W);
      else pass_cnt++;
    end
    flush = 1'b1;
    step();
    total_cnt++;
    if (RegWriteW !== 1'b0 || ResultW !== 32'h0 || WriteRegW !== 5'd0 || PC8W !== 32'h0)
      $display("FAIL flush_bubble got %b/%h/%0d/%h want 0/00000000/0/00000000",
               RegWriteW, ResultW, WriteRegW, PC8W);
    else pass_cnt++;
    flush = 1'b0; stall = 1'b0; RegWriteM = 1'b1;
    step();
    total_cnt++;
    if (ResultW !== 32'h00005678 || WriteRegW !== 5'd9 || RegWriteW !== 1'b1)
      $display("FAIL capture_B got %h/%0d/%b want 00005678/9/1", ResultW, WriteRegW, RegWriteW);
    else pass_cnt++;
    stall = 1'b1; reset = 1'b1;
    step();
    total_cnt++;
    if (ResultW !== 32'h0 || RegWriteW !== 1'b0 || WriteRegW !== 5'd0)
      $display("FAIL reset_in_stall got %h/%b/%0d want 00000000/0/0", ResultW, RegWriteW, WriteRegW);
    else pass_cnt++;
    reset = 1'b0; stall = 1'b0; ALUOutM = 32'h0000ABCD; WriteRegM = 5'd12;
    step();
    total_cnt++;
    if (ResultW !== 32'h0000ABCD || WriteRegW !== 5'd12 || RegWriteW !== 1'b1)
      $display("FAIL capture_after_reset got %h/%0d/%b want 0000ABCD/12/1", ResultW, WriteRegW, RegWriteW);
    else pass_cnt++;
  endtask

  task automatic test_zero_guard_pc8();
    RegWriteM = 1'b1; WriteRegM = 5'd0; MemtoRegM = 2'b00; ALUOutM = 32'h00000055;
    step();
    total_cnt++;
    if (RegWriteW !== 1'b0) $display("FAIL zero_guard got %b want 0", RegWriteW);
    else pass_cnt++;
    WriteRegM = 5'd31; MemtoRegM = 2'b10; PC8M = 32'h00003008;
    step();
    total_cnt++;
    if (ResultW !== 32'h00003008 || RegWriteW !== 1'b1 || PC8W !== 32'h00003008)
      $display("FAIL pc8_select got %h/%b/%h want 00003008/1/00003008", ResultW, RegWriteW, PC8W);
    else pass_cnt++;
    MemtoRegM = 2'b11; ALUOutM = 32'h00000077;
    step();
    total_cnt++;
    if (ResultW !== 32'h00000077) $display("FAIL memtoreg11_alu got %h want 00000077", ResultW);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0; total_cnt = 0;
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
    ReadDataM = '0; AddrLow2M = '0; LoadModeM = '0; RtDataM = '0;
    ALUOutM = '0; PC8M = '0; MemtoRegM = '0; RegWriteM = 1'b0; WriteRegM = '0;
    #2;
    test_reset();
    test_byte_loads();
    test_half_loads();
    test_lwl_lwr();
    test_stall_flush();
    test_zero_guard_pc8();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
